// File: rtl/arith_ctrl_pkg.sv
// arith_ctrl_pkg: shared FSM state, opcode encodings and widths for the arithmetic arbiter
package arith_ctrl_pkg;
  localparam int OPND_W = 4;
  localparam int RES_W = 8;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/ArithmeticUnit.sv
// ArithmeticUnit: combinational add/sub/mul/div datapath with divide-by-zero flag
module ArithmeticUnit
  import arith_ctrl_pkg::*;
(
  input  logic [1:0]        operation,
  input  logic [OPND_W-1:0] A,
  input  logic [OPND_W-1:0] B,
  output logic [RES_W-1:0]  result,
  output logic              error
);
  assign error = operation == OP_DIV && B == '0;
  assign result = operation == OP_ADD ? RES_W'(A) + RES_W'(B) :
                  operation == OP_SUB ? RES_W'(A) - RES_W'(B) :
                  operation == OP_MUL ? RES_W'(A) * RES_W'(B) :
                  B == '0 ? '0 : RES_W'(A / B);
endmodule

// File: rtl/arith_arbiter.sv
// arith_arbiter: round-robin arbiter between two requesters sharing one ArithmeticUnit,
// with a held response handshake and a saturating error counter
module arith_arbiter
  import arith_ctrl_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [OPND_W-1:0] req0_a,
  input  logic [OPND_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [OPND_W-1:0] req1_a,
  input  logic [OPND_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_error,
  output logic [7:0]        err_count,
  output logic              busy
);
  logic [1:0] sync;
  logic rst_s;
  state_t state;
  logic [3:0] cnt;
  logic last_grant;
  logic [1:0] op_q;
  logic [OPND_W-1:0] a_q, b_q;
  logic [RES_W-1:0] alu_res;
  logic alu_err, idle;
  // reset asserts at once but releases two clocks later
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= {sync[0], 1'b1};
  assign rst_s = sync[1];
  assign idle = rst_s && state == IDLE;
  assign req0_ready = idle && req0_valid && !(req1_valid && !last_grant);
  assign req1_ready = idle && req1_valid && !(req0_valid && last_grant);
  ArithmeticUnit u_alu (
    .operation(op_q),
    .A(a_q),
    .B(b_q),
    .result(alu_res),
    .error(alu_err)
  );
  always_ff @(posedge clk or negedge rst_s)
    if (!rst_s) begin
      state <= IDLE;
      cnt <= '0;
      last_grant <= 1'b1;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_result <= '0;
      rsp_error <= 1'b0;
      err_count <= '0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req0_ready || req1_ready) begin
          op_q <= req1_ready ? req1_op : req0_op;
          a_q <= req1_ready ? req1_a : req0_a;
          b_q <= req1_ready ? req1_b : req0_b;
          rsp_id <= req1_ready;
          last_grant <= req1_ready;
          cnt <= 4'(EXEC_CYCLES - 1);
          busy <= 1'b1;
          state <= EXEC;
        end
        EXEC: if (cnt == '0) begin
          rsp_result <= alu_res;
          rsp_error <= alu_err;
          rsp_valid <= 1'b1;
          state <= RESP;
        end else cnt <= cnt - 4'd1;
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          busy <= 1'b0;
          err_count <= rsp_error && err_count != 8'hff ? err_count + 8'd1 : err_count;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
